// File: rtl/acc_adapter_rsp_pkg.sv
// Shared types and helpers for the accelerator adapter response path.
package acc_adapter_rsp_pkg;

  localparam int unsigned RdWidth = 5;

  typedef enum logic {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } rsp_state_e;

  // Register index of the second half of a dual writeback; wraps 31 -> 0.
  function automatic logic [RdWidth-1:0] rd_next(input logic [RdWidth-1:0] rd);
    return rd + RdWidth'(1);
  endfunction

endpackage

// File: rtl/acc_adapter_rsp_if.sv
// Response channels of the accelerator adapter: C-side writeback in, X-side response out.
interface acc_adapter_rsp_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1
) ();

  logic                   c_rsp_valid;
  logic                   c_rsp_ready;
  logic [IdWidth-1:0]     c_rsp_id;
  logic [4:0]             c_rsp_rd;
  logic [2*DataWidth-1:0] c_rsp_data;
  logic                   c_rsp_dualwb;
  logic                   c_rsp_error;

  logic                   x_rsp_valid;
  logic                   x_rsp_ready;
  logic [4:0]             x_rsp_rd;
  logic [DataWidth-1:0]   x_rsp_data;
  logic                   x_rsp_error;

  modport slave (
    input  c_rsp_valid, c_rsp_id, c_rsp_rd, c_rsp_data, c_rsp_dualwb, c_rsp_error,
    output c_rsp_ready,
    output x_rsp_valid, x_rsp_rd, x_rsp_data, x_rsp_error,
    input  x_rsp_ready
  );

  modport master (
    output c_rsp_valid, c_rsp_id, c_rsp_rd, c_rsp_data, c_rsp_dualwb, c_rsp_error,
    input  c_rsp_ready,
    input  x_rsp_valid, x_rsp_rd, x_rsp_data, x_rsp_error,
    output x_rsp_ready
  );

endinterface

// File: rtl/acc_adapter_rsp_fifo.sv
// Non-fall-through FIFO: a pushed entry appears on data_o the cycle after the push.
module acc_adapter_rsp_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];

  // Storage is cleared on reset so the X-side payload reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + AddrW'(1);
      end
      if (pop_ok) rptr_q <= rptr_q + AddrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/acc_adapter_rsp.sv
// Accelerator adapter response path: buffers C-side writebacks and replays them on the X interface.
// Define ACC_ADAPTER_DUAL_WB_EN to split 64-bit dual writebacks into two X beats.
//
// state    | meaning
// S_FIRST  | presenting rd and low word of the FIFO head
// S_SECOND | presenting rd+1 and high word of a dual-writeback head
module acc_adapter_rsp
  import acc_adapter_rsp_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 1,
  parameter int unsigned Depth          = 4,
  parameter int unsigned MaxOutstanding = 8,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_issue_i,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                outstanding_full_o,
  output logic                spurious_o,
  acc_adapter_rsp_if.slave    rsp
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [RdWidth-1:0]     rd;
`ifdef ACC_ADAPTER_DUAL_WB_EN
    logic [2*DataWidth-1:0] data;
    logic                   dualwb;
`else
    logic [DataWidth-1:0]   data;
`endif
    logic                   error;
  } entry_t;

  entry_t               push_entry, head;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop, x_hs, issue;
  logic                 head_dual;
  logic [DataWidth-1:0] hi_word;
  logic                 unused_bits;
  rsp_state_e           state_q;
  logic [CntWidth-1:0]  cnt_q;
  logic                 spurious_q;

  // Ready depends on fullness alone, so a full FIFO refuses a push even while popping.
  assign rsp.c_rsp_ready = !fifo_full;
  assign push            = rsp.c_rsp_valid && !fifo_full;
  assign rsp.x_rsp_valid = !fifo_empty;
  assign x_hs            = !fifo_empty && rsp.x_rsp_ready;
  assign pop             = x_hs && (state_q == S_SECOND || !head_dual);

  always_comb begin
    push_entry       = '0;
    push_entry.id    = rsp.c_rsp_id;
    push_entry.rd    = rsp.c_rsp_rd;
    push_entry.error = rsp.c_rsp_error;
`ifdef ACC_ADAPTER_DUAL_WB_EN
    push_entry.data   = rsp.c_rsp_data;
    push_entry.dualwb = rsp.c_rsp_dualwb;
`else
    push_entry.data   = rsp.c_rsp_data[DataWidth-1:0];
`endif
  end

`ifdef ACC_ADAPTER_DUAL_WB_EN
  assign head_dual   = head.dualwb;
  assign hi_word     = head.data[2*DataWidth-1:DataWidth];
  assign unused_bits = ^head.id;
`else
  assign head_dual   = 1'b0;
  assign hi_word     = '0;
  assign unused_bits = ^{head.id, rsp.c_rsp_dualwb, rsp.c_rsp_data[2*DataWidth-1:DataWidth]};
`endif

  acc_adapter_rsp_fifo #(
    .Depth (Depth),
    .Width ($bits(entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FIRST;
    end else if (x_hs) begin
      case (state_q)
        S_FIRST:  state_q <= head_dual ? S_SECOND : S_FIRST;
        S_SECOND: state_q <= S_FIRST;
        default:  state_q <= S_FIRST;
      endcase
    end
  end

  assign rsp.x_rsp_rd    = (state_q == S_SECOND) ? rd_next(head.rd) : head.rd;
  assign rsp.x_rsp_data  = (state_q == S_SECOND) ? hi_word : head.data[DataWidth-1:0];
  assign rsp.x_rsp_error = head.error;

  // An issue paired with a push in the same cycle nets out; a lone push at zero is spurious.
  assign issue = req_issue_i && !outstanding_full_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      spurious_q <= push && !issue && (cnt_q == '0);
      if (issue && !push) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (push && !issue && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign outstanding_o      = cnt_q;
  assign outstanding_full_o = (cnt_q == CntMax);
  assign spurious_o         = spurious_q;

  a_no_issue_when_full : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(req_issue_i && outstanding_full_o)
  );

endmodule

// File: tb/tb_acc_adapter_rsp.sv
// Self-checking bench for acc_adapter_rsp: directed vector table, corner sequences, random vs model.
module tb_acc_adapter_rsp;

  localparam int DEPTH = 4;
  localparam int MAXO  = 8;
`ifdef ACC_ADAPTER_DUAL_WB_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic       clk_i       = 1'b0;
  logic       rst_ni      = 1'b1;
  logic       req_issue_i = 1'b0;
  logic [3:0] outstanding_o;
  logic       outstanding_full_o;
  logic       spurious_o;

  acc_adapter_rsp_if #(.DataWidth(32), .IdWidth(1)) rsp_if ();

  acc_adapter_rsp #(
    .DataWidth      (32),
    .IdWidth        (1),
    .Depth          (DEPTH),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .req_issue_i        (req_issue_i),
    .outstanding_o      (outstanding_o),
    .outstanding_full_o (outstanding_full_o),
    .spurious_o         (spurious_o),
    .rsp                (rsp_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } beat_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        dual;
    logic        err;
    int          nb;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic [4:0]  rd1;
    logic [31:0] d1;
  } vec_t;

  // Reference model: expected X beats in order, beats left per buffered entry, request count.
  beat_t m_beats[$];
  int    m_left[$];
  int    m_cnt;
  bit    m_spur;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("c_ready", 64'(rsp_if.c_rsp_ready), 64'(m_left.size() < DEPTH));
    chk("x_valid", 64'(rsp_if.x_rsp_valid), 64'(m_beats.size() > 0));
    if (m_beats.size() > 0) begin
      chk("x_rd", 64'(rsp_if.x_rsp_rd), 64'(m_beats[0].rd));
      chk("x_data", 64'(rsp_if.x_rsp_data), 64'(m_beats[0].data));
      chk("x_error", 64'(rsp_if.x_rsp_error), 64'(m_beats[0].err));
    end
    chk("outstanding", 64'(outstanding_o), 64'(m_cnt));
    chk("outstanding_full", 64'(outstanding_full_o), 64'(m_cnt == MAXO));
    chk("spurious", 64'(spurious_o), 64'(m_spur));
  endtask

  // One clock: model consumes the inputs held through the edge, then DUT is checked 1ns later.
  task automatic tick();
    bit    c_hs, x_hs, inc;
    beat_t b;
    @(posedge clk_i);
    c_hs = rsp_if.c_rsp_valid && (m_left.size() < DEPTH);
    x_hs = rsp_if.x_rsp_ready && (m_beats.size() > 0);
    inc  = req_issue_i && (m_cnt < MAXO);
    if (x_hs) begin
      void'(m_beats.pop_front());
      m_left[0] = m_left[0] - 1;
      if (m_left[0] == 0) void'(m_left.pop_front());
    end
    m_spur = c_hs && !inc && (m_cnt == 0);
    if (inc && !c_hs) m_cnt++;
    else if (c_hs && !inc && m_cnt > 0) m_cnt--;
    if (c_hs) begin
      b.rd   = rsp_if.c_rsp_rd;
      b.data = rsp_if.c_rsp_data[31:0];
      b.err  = rsp_if.c_rsp_error;
      m_beats.push_back(b);
      if (DUAL && rsp_if.c_rsp_dualwb) begin
        b.rd   = rsp_if.c_rsp_rd + 5'd1;
        b.data = rsp_if.c_rsp_data[63:32];
        m_beats.push_back(b);
        m_left.push_back(2);
      end else begin
        m_left.push_back(1);
      end
    end
    #1;
    check_model();
  endtask

  task automatic set_rsp(input logic [4:0] rd, input logic [63:0] data, input logic dual,
                         input logic err);
    rsp_if.c_rsp_valid  = 1'b1;
    rsp_if.c_rsp_id     = 1'b0;
    rsp_if.c_rsp_rd     = rd;
    rsp_if.c_rsp_data   = data;
    rsp_if.c_rsp_dualwb = dual;
    rsp_if.c_rsp_error  = err;
  endtask

  task automatic do_reset();
    rst_ni                = 1'b0;
    req_issue_i           = 1'b0;
    rsp_if.c_rsp_valid    = 1'b0;
    rsp_if.x_rsp_ready    = 1'b0;
    m_beats.delete();
    m_left.delete();
    m_cnt  = 0;
    m_spur = 1'b0;
    #2;
    chk("rst_x_valid", 64'(rsp_if.x_rsp_valid), 64'd0);
    chk("rst_c_ready", 64'(rsp_if.c_rsp_ready), 64'd1);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_full", 64'(outstanding_full_o), 64'd0);
    chk("rst_spurious", 64'(spurious_o), 64'd0);
    chk("rst_x_rd", 64'(rsp_if.x_rsp_rd), 64'd0);
    chk("rst_x_data", 64'(rsp_if.x_rsp_data), 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];

    vecs[0] = '{5'd5, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0, 1, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0};
`ifdef ACC_ADAPTER_DUAL_WB_EN
    vecs[1] = '{5'd10, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 2, 5'd10, 32'h33334444, 5'd11, 32'h11112222};
    vecs[2] = '{5'd31, 64'hAAAA_5555_0123_4567, 1'b1, 1'b0, 2, 5'd31, 32'h01234567, 5'd0, 32'hAAAA5555};
    vecs[3] = '{5'd3, 64'hCAFE_F00D_8765_4321, 1'b1, 1'b1, 2, 5'd3, 32'h87654321, 5'd4, 32'hCAFEF00D};
`else
    vecs[1] = '{5'd10, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 1, 5'd10, 32'h33334444, 5'd0, 32'h0};
    vecs[2] = '{5'd31, 64'hAAAA_5555_0123_4567, 1'b1, 1'b0, 1, 5'd31, 32'h01234567, 5'd0, 32'h0};
    vecs[3] = '{5'd3, 64'hCAFE_F00D_8765_4321, 1'b1, 1'b1, 1, 5'd3, 32'h87654321, 5'd0, 32'h0};
`endif

    rsp_if.c_rsp_valid  = 1'b0;
    rsp_if.c_rsp_id     = 1'b0;
    rsp_if.c_rsp_rd     = 5'd0;
    rsp_if.c_rsp_data   = 64'd0;
    rsp_if.c_rsp_dualwb = 1'b0;
    rsp_if.c_rsp_error  = 1'b0;
    rsp_if.x_rsp_ready  = 1'b0;
    #1;
    do_reset();

    // Single, dual, rd wrap and error responses from the vector table.
    for (int v = 0; v < 4; v++) begin
      rsp_if.x_rsp_ready = 1'b0;
      req_issue_i        = 1'b1;
      tick();
      chk("vec_cnt_issue", 64'(outstanding_o), 64'd1);
      req_issue_i = 1'b0;
      set_rsp(vecs[v].rd, vecs[v].data, vecs[v].dual, vecs[v].err);
      #1;
      chk("vec_no_fallthru", 64'(rsp_if.x_rsp_valid), 64'd0);
      tick();
      rsp_if.c_rsp_valid = 1'b0;
      chk("vec_valid", 64'(rsp_if.x_rsp_valid), 64'd1);
      chk("vec_rd0", 64'(rsp_if.x_rsp_rd), 64'(vecs[v].rd0));
      chk("vec_d0", 64'(rsp_if.x_rsp_data), 64'(vecs[v].d0));
      chk("vec_err0", 64'(rsp_if.x_rsp_error), 64'(vecs[v].err));
      chk("vec_cnt_done", 64'(outstanding_o), 64'd0);
      rsp_if.x_rsp_ready = 1'b1;
      tick();
      if (vecs[v].nb == 2) begin
        chk("vec_rd1", 64'(rsp_if.x_rsp_rd), 64'(vecs[v].rd1));
        chk("vec_d1", 64'(rsp_if.x_rsp_data), 64'(vecs[v].d1));
        chk("vec_err1", 64'(rsp_if.x_rsp_error), 64'(vecs[v].err));
        tick();
      end
      chk("vec_drained", 64'(rsp_if.x_rsp_valid), 64'd0);
    end

    // Backpressure: fill the FIFO, hold a fifth response, then release the core side.
    rsp_if.x_rsp_ready = 1'b0;
    req_issue_i        = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    req_issue_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_rsp(5'(i + 1), {32'h0, 32'h1000 + 32'(i)}, 1'b0, 1'b0);
      tick();
    end
    chk("bp_ready_low", 64'(rsp_if.c_rsp_ready), 64'd0);
    chk("bp_cnt", 64'(outstanding_o), 64'd1);
    set_rsp(5'd20, 64'h0000_0000_0000_2020, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_hold_rd", 64'(rsp_if.x_rsp_rd), 64'd1);
    chk("bp_hold_data", 64'(rsp_if.x_rsp_data), 64'h1000);
    rsp_if.x_rsp_ready = 1'b1;
    tick();
    chk("bp_ready_back", 64'(rsp_if.c_rsp_ready), 64'd1);
    chk("bp_next_rd", 64'(rsp_if.x_rsp_rd), 64'd2);
    tick();
    rsp_if.c_rsp_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_cnt0", 64'(outstanding_o), 64'd0);
    chk("bp_empty", 64'(rsp_if.x_rsp_valid), 64'd0);

    // Counter saturation, issue+push cancellation, spurious response.
    for (int i = 0; i < MAXO; i++) begin
      req_issue_i = 1'b1;
      tick();
    end
    req_issue_i = 1'b0;
    chk("cnt_max", 64'(outstanding_o), 64'd8);
    chk("cnt_full", 64'(outstanding_full_o), 64'd1);
    set_rsp(5'd7, 64'h77, 1'b0, 1'b0);
    tick();
    chk("cnt_dec", 64'(outstanding_o), 64'd7);
    chk("cnt_not_full", 64'(outstanding_full_o), 64'd0);
    req_issue_i = 1'b1;
    tick();
    req_issue_i = 1'b0;
    chk("cnt_same", 64'(outstanding_o), 64'd7);
    for (int i = 0; i < 7; i++) tick();
    chk("cnt_zero", 64'(outstanding_o), 64'd0);
    set_rsp(5'd9, 64'h99, 1'b0, 1'b0);
    tick();
    rsp_if.c_rsp_valid = 1'b0;
    chk("spur_pulse", 64'(spurious_o), 64'd1);
    chk("spur_cnt", 64'(outstanding_o), 64'd0);
    chk("spur_deliver_valid", 64'(rsp_if.x_rsp_valid), 64'd1);
    chk("spur_deliver_rd", 64'(rsp_if.x_rsp_rd), 64'd9);
    tick();
    chk("spur_clear", 64'(spurious_o), 64'd0);

    // Reset while a dual response is half delivered and another is queued.
    rsp_if.x_rsp_ready = 1'b0;
    req_issue_i        = 1'b1;
    tick();
    tick();
    req_issue_i = 1'b0;
    set_rsp(5'd12, 64'hBBBB_CCCC_DDDD_EEEE, 1'b1, 1'b0);
    tick();
    set_rsp(5'd14, 64'h1414, 1'b0, 1'b0);
    tick();
    rsp_if.c_rsp_valid = 1'b0;
    rsp_if.x_rsp_ready = 1'b1;
    tick();
    rsp_if.x_rsp_ready = 1'b0;
    #1;
    do_reset();
    rsp_if.x_rsp_ready = 1'b1;
    tick();
    tick();
    set_rsp(5'd2, 64'h0202, 1'b1, 1'b0);
    tick();
    rsp_if.c_rsp_valid = 1'b0;
    chk("post_reset_rd", 64'(rsp_if.x_rsp_rd), 64'd2);
    for (int i = 0; i < 3; i++) tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      req_issue_i         = ($urandom_range(0, 1) == 0) && (m_cnt < MAXO);
      rsp_if.c_rsp_valid  = ($urandom_range(0, 9) < 4);
      rsp_if.c_rsp_id     = 1'($urandom);
      rsp_if.c_rsp_rd     = 5'($urandom);
      rsp_if.c_rsp_data   = {$urandom, $urandom};
      rsp_if.c_rsp_dualwb = 1'($urandom);
      rsp_if.c_rsp_error  = ($urandom_range(0, 7) == 0);
      rsp_if.x_rsp_ready  = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
